// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : shared types and constants for the instruction-fetch front end
// Revision  : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam int INSTR_W  = 32;
    localparam int PC_STEP  = 4;
    // Entries carry the widest supported PC; narrower builds zero-extend.
    localparam int PC_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [PC_MAX_W-1:0] pc;
        logic [INSTR_W-1:0]  instr;
        logic                fault;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo : synchronous FIFO of fetch entries with flush and occupancy count
// Revision   : 1.0
// ============================================================================
`default_nettype none

module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  wr_data,
    input  logic          pop,
    output fetch_entry_t  rd_data,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_push;
    logic [AW-1:0] w_wr_addr;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CW'(DEPTH));
    assign count     = r_count;
    assign rd_data   = r_mem[r_rd_ptr];
    assign w_pop     = pop && !empty;
    // A flush empties the buffer first, so a push alongside it always lands.
    assign w_push    = push && (flush || !full || w_pop);
    assign w_wr_addr = flush ? '0 : r_wr_ptr;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= w_push ? AW'(1) : '0;
            r_count  <= w_push ? CW'(1) : '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : PC owner, imem request/response handling, redirect flush, decode stream
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect target -> fault entry)
// Revision   : 1.0
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              FQ_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [XLEN-1:0]     imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [INSTR_W-1:0]  imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [XLEN-1:0]     if_pc,
    output logic                if_fault
);

    localparam int AW = $clog2(FQ_DEPTH);
    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam int SW = CW + 1;

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop;
    logic [XLEN-1:0] r_sq_pc [FQ_DEPTH];
    logic [AW-1:0]   r_sq_wr;
    logic [AW-1:0]   r_sq_rd;

    logic            w_redir;
    logic            w_misalign;
    logic [XLEN-1:0] w_target;
    logic            w_room;
    logic            w_acc;
    logic            w_rsp;
    logic            w_rsp_push;
    logic [CW-1:0]   w_out_next;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;
    logic            w_fifo_empty;
    logic            w_fifo_full;
    logic [CW-1:0]   w_fifo_count;

    assign w_redir = redirect_valid && (r_state != IDLE);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_misalign = w_redir && (redirect_pc[1:0] != 2'b00);
    assign w_target   = redirect_pc;
`else
    assign w_misalign = 1'b0;
    assign w_target   = {redirect_pc[XLEN-1:2], 2'b00};
`endif

    // Responses still owed (including ones to be dropped) count against buffer space.
    assign w_room         = ({1'b0, w_fifo_count} + {1'b0, r_outstanding}) < SW'(FQ_DEPTH);
    assign imem_req_valid = (r_state == RUN) && !w_redir && w_room;
    assign imem_req_addr  = r_pc;
    assign w_acc          = imem_req_valid && imem_req_ready;
    assign w_rsp          = imem_rsp_valid && (r_outstanding != '0);
    assign w_out_next     = r_outstanding + CW'(w_acc) - CW'(w_rsp);
    assign w_rsp_push     = w_rsp && (r_drop == '0) && !w_redir;

    always_comb begin
        w_push_entry = '0;
        if (w_misalign) begin
            w_push_entry.pc    = PC_MAX_W'(w_target);
            w_push_entry.fault = 1'b1;
        end else begin
            w_push_entry.pc    = PC_MAX_W'(r_sq_pc[r_sq_rd]);
            w_push_entry.instr = imem_rsp_data;
        end
    end

    fetch_fifo #(
        .DEPTH (FQ_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (w_redir),
        .push    (w_rsp_push || w_misalign),
        .wr_data (w_push_entry),
        .pop     (if_valid && if_ready),
        .rd_data (w_head),
        .empty   (w_fifo_empty),
        .full    (w_fifo_full),
        .count   (w_fifo_count)
    );

    // PC of every accepted request, consumed in order as responses return.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_sq_pc[r_sq_wr] <= r_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_sq_wr       <= '0;
            r_sq_rd       <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (w_acc) begin
                r_sq_wr <= r_sq_wr + AW'(1);
            end
            if (w_rsp) begin
                r_sq_rd <= r_sq_rd + AW'(1);
            end
            case (r_state)
                IDLE:    r_state <= RUN;
                RUN:     if (w_redir && w_misalign)  r_state <= FAULT;
                FAULT:   if (w_redir && !w_misalign) r_state <= RUN;
                default: r_state <= IDLE;
            endcase
            if (w_redir) begin
                r_pc   <= w_target;
                r_drop <= w_out_next;
            end else begin
                if (w_acc) begin
                    r_pc <= r_pc + XLEN'(PC_STEP);
                end
                if (w_rsp && (r_drop != '0)) begin
                    r_drop <= r_drop - CW'(1);
                end
            end
        end
    end

    assign if_valid = !w_fifo_empty;
    assign if_instr = w_fifo_empty ? '0 : w_head.instr;
    assign if_pc    = w_fifo_empty ? RESET_PC : w_head.pc[XLEN-1:0];

`ifdef FETCH_MISALIGN_TRAP_EN
    assign if_fault = !w_fifo_empty && w_head.fault;
`else
    assign if_fault = 1'b0;
    logic unused_cfg;
    assign unused_cfg = ^{redirect_pc[1:0], w_head.fault};
`endif

    generate
        if (XLEN < PC_MAX_W) begin : g_pc_hi
            logic unused_pc_hi;
            assign unused_pc_hi = ^{w_head.pc[PC_MAX_W-1:XLEN], w_fifo_full};
        end else begin : g_pc_full
            logic unused_full;
            assign unused_full = w_fifo_full;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : directed self-checking bench for fetch_unit with a latency-configurable memory
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_fault;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0),
        .FQ_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_fault       (if_fault)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] acc_log[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_instr[$];
    logic        pop_fault[$];
    int          cyc = 0;
    int          lat = 1;
    logic        last_req_valid;

    // Memory contents: instruction word derived from its address.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic clear_logs();
        acc_log.delete();
        pop_pc.delete();
        pop_instr.delete();
        pop_fault.delete();
    endtask

    // One clock: sample handshakes mid-cycle, then update the memory model after the edge.
    task automatic step();
        logic        acc;
        logic        popped;
        logic        rspv;
        logic        pf;
        logic [31:0] addr;
        logic [31:0] ppc;
        logic [31:0] pins;
        @(negedge clk);
        acc            = imem_req_valid && imem_req_ready;
        addr           = imem_req_addr;
        popped         = if_valid && if_ready;
        ppc            = if_pc;
        pins           = if_instr;
        pf             = if_fault;
        rspv           = imem_rsp_valid;
        last_req_valid = imem_req_valid;
        @(posedge clk);
        #1;
        cyc++;
        redirect_valid = 1'b0;
        if (rspv && (pend.size() > 0)) void'(pend.pop_front());
        if (acc) begin
            pend.push_back('{addr, cyc + lat - 1});
            acc_log.push_back(addr);
        end
        if (popped) begin
            pop_pc.push_back(ppc);
            pop_instr.push_back(pins);
            pop_fault.push_back(pf);
        end
        if ((pend.size() > 0) && (pend[0].due <= cyc)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(pend[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        pend.delete();
        clear_logs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_pc    = target;
        redirect_valid = 1'b1;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        // Reset values and basic streaming with a 1-cycle memory.
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_req_addr",  imem_req_addr,  32'h0);
        check("rst_if_valid",  if_valid,       0);
        check("rst_if_instr",  if_instr,       32'h0);
        check("rst_if_pc",     if_pc,          32'h0);
        check("rst_if_fault",  if_fault,       0);
        do_reset();
        lat = 1; if_ready = 1'b1;
        step();
        check("t1_idle_no_req", last_req_valid, 0);
        steps(10);
        check("t1_acc0", acc_log[0], 32'h0);
        check("t1_acc1", acc_log[1], 32'h4);
        check("t1_acc2", acc_log[2], 32'h8);
        check("t1_pc0", pop_pc[0], 32'h0);
        check("t1_pc1", pop_pc[1], 32'h4);
        check("t1_pc2", pop_pc[2], 32'h8);
        check("t1_in0", pop_instr[0], 32'hC0DE_0000);
        check("t1_in2", pop_instr[2], 32'hC0DE_0008);

        // Decode stalled: only FQ_DEPTH requests may be accepted.
        do_reset();
        lat = 1; if_ready = 1'b0;
        steps(22);
        check("t2_acc_count", acc_log.size(), 4);
        check("t2_acc3", acc_log[3], 32'hC);
        check("t2_full_valid", if_valid, 1);
        if_ready = 1'b1;
        steps(20);
        check("t2_pc0", pop_pc[0], 32'h0);
        check("t2_pc3", pop_pc[3], 32'hC);
        check("t2_pc4", pop_pc[4], 32'h10);
        check("t2_in3", pop_instr[3], 32'hC0DE_000C);

        // Redirect with three requests outstanding on a 3-cycle memory.
        do_reset();
        lat = 3; if_ready = 1'b1;
        for (int i = 0; i < 20 && pend.size() != 3; i++) step();
        check("t3_outstanding3", pend.size(), 3);
        redirect(32'h100);
        check("t3_req_suppressed", last_req_valid, 0);
        clear_logs();
        steps(25);
        check("t3_acc0", acc_log[0], 32'h100);
        check("t3_pc0", pop_pc[0], 32'h100);
        check("t3_in0", pop_instr[0], 32'hC0DE_0100);
        check("t3_pc1", pop_pc[1], 32'h104);

        // Redirect while the port is busy issuing and receiving every cycle.
        do_reset();
        lat = 1; if_ready = 1'b1;
        steps(8);
        redirect(32'h200);
        check("t4_req_suppressed", last_req_valid, 0);
        clear_logs();
        steps(15);
        check("t4_pc0", pop_pc[0], 32'h200);
        check("t4_pc1", pop_pc[1], 32'h204);
        check("t4_pc2", pop_pc[2], 32'h208);
        check("t4_in0", pop_instr[0], 32'hC0DE_0200);

        // Misaligned redirect target.
        do_reset();
        lat = 1; if_ready = 1'b1;
        steps(6);
        redirect(32'h102);
        clear_logs();
        steps(12);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("t5_no_req", acc_log.size(), 0);
        check("t5_fault_pc", pop_pc[0], 32'h102);
        check("t5_fault_bit", pop_fault[0], 1);
        check("t5_fault_instr", pop_instr[0], 32'h0);
        check("t5_single", pop_pc.size(), 1);
        redirect(32'h200);
        steps(10);
        check("t5_resume_pc", pop_pc[1], 32'h200);
        check("t5_resume_fault", pop_fault[1], 0);
`else
        check("t5_aligned_pc", pop_pc[0], 32'h100);
        check("t5_no_fault", pop_fault[0], 0);
        check("t5_acc0", acc_log[0], 32'h100);
`endif

        // Asynchronous reset with the buffer full.
        do_reset();
        lat = 1; if_ready = 1'b0;
        steps(12);
        check("t6_full_valid", if_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_req_valid", imem_req_valid, 0);
        check("t6_req_addr",  imem_req_addr,  32'h0);
        check("t6_if_valid",  if_valid,       0);
        check("t6_if_pc",     if_pc,          32'h0);
        check("t6_if_instr",  if_instr,       32'h0);
        check("t6_if_fault",  if_fault,       0);
        do_reset();
        if_ready = 1'b1;
        steps(10);
        check("t6_restart_acc", acc_log[0], 32'h0);
        check("t6_restart_pc",  pop_pc[0],  32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
